// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Round-robin arbiter that shares one uart_tx transmitter among NUM_REQ byte
// producers. A winner is picked combinationally while idle. Its character is
// latched on the accepting edge. The arbiter then drives request_to_send for
// a launch window and holds the line for a full frame slot. uart_tx has no
// done flag, so the slot length is timed here from the shared baud parameters.
//
// Ports:
//   clk        : system clock, shared with uart_tx
//   reset      : asynchronous active-high reset, same net as uart_tx.reset
//   req_valid  : per-requester "character offered" flags
//   req_data   : requester i's character at [i*DATA_BITS +: DATA_BITS]
//   req_ready  : one-hot (or zero) accept strobe, combinational in IDLE
//   tx_data    : latched character -> uart_tx.data_to_transmit
//   tx_request : launch pulse      -> uart_tx.request_to_send
//   busy       : high while a frame slot is in progress
//   grant_id   : index of the most recently accepted requester
module uart_tx_arbiter #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int DATA_BITS     = 8,
  parameter int NUM_REQ       = 4
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [NUM_REQ-1:0]                             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]                   req_data,
  output logic [NUM_REQ-1:0]                             req_ready,
  output logic [DATA_BITS-1:0]                           tx_data,
  output logic                                           tx_request,
  output logic                                           busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DIV           = CLK_FREQUENCY / BAUD_RATE;
  localparam int LAUNCH_CYCLES = 2 * DIV;
  localparam int FRAME_CYCLES  = (DATA_BITS + 4) * DIV;
  localparam int CNT_W         = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LAUNCH_LAST = CNT_W'(LAUNCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q;
  logic               accept;

  logic               win_valid;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    ptr_next;
  logic [DATA_BITS-1:0] win_data;
  logic               hi_found;
  logic [ID_W-1:0]    hi_idx;
  logic [ID_W-1:0]    lo_idx;

  // Round-robin pick: the lowest set index at or above the pointer wins;
  // if there is none, the search wraps and the lowest set index overall wins.
  // Scanning downward leaves the lowest match in each candidate.
  always_comb begin
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    win_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_valid = 1'b1;
        lo_idx    = ID_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_idx) win_data = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign ptr_next = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);

  // Next state and slot counter. The counter runs through the whole slot:
  // LAUNCH covers 0..LAUNCH_CYCLES-1 and HOLD continues up to FRAME_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAUNCH_LAST) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == FRAME_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      tx_data  <= '0;
      grant_id <= '0;
    end else if (accept) begin
      ptr_q    <= ptr_next;
      tx_data  <= win_data;
      grant_id <= win_idx;
    end
  end

  // req_ready is gated by reset as well: the state is forced to IDLE during
  // reset, and the requesters must not see an accept strobe at that time.
  assign req_ready  = (state_q == S_IDLE && win_valid && !reset)
                      ? (NUM_REQ'(1) << win_idx) : '0;
  assign tx_request = (state_q == S_LAUNCH);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int CLK_FREQUENCY = 16;
  localparam int BAUD_RATE     = 4;
  localparam int DATA_BITS     = 8;
  localparam int NUM_REQ       = 4;
  localparam int LAUNCH        = 8;
  localparam int FRAME         = 48;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_request;
  logic        busy;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .BAUD_RATE    (BAUD_RATE),
    .DATA_BITS    (DATA_BITS),
    .NUM_REQ      (NUM_REQ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_request(tx_request),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // Distinct character per lane, so a wrong-lane capture is visible.
  function automatic logic [31:0] lanes(input logic [7:0] base);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = base ^ (8'h11 * 8'(i));
    return r;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v == (4'b1 << i)) return i;
    return -1;
  endfunction

  // Reference: round-robin search from the pointer, modulo NUM_REQ.
  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0] valid;
    logic [7:0] data;
    logic [3:0] exp_ready;
    logic [1:0] exp_gid;
    bit         exp_acc;
  } vec_t;

  vec_t tbl[8];

  // Reference model state: slot age in cycles (-1 means idle).
  int          m_age, m_ptr, m_gid;
  logic [7:0]  m_data;

  initial begin
    int acc_times[$];
    int acc_ids[$];
    int cnt_req, cnt_busy, elapsed, w;
    logic [3:0]  e_ready;
    logic [63:0] exp_vec, act_vec;

    // Pointer starts at 0; each row's winner moves it to winner+1.
    tbl[0] = '{4'b0100, 8'hA5, 4'b0100, 2'd2, 1'b1};
    tbl[1] = '{4'b1001, 8'h3C, 4'b1000, 2'd3, 1'b1};
    tbl[2] = '{4'b1001, 8'h5A, 4'b0001, 2'd0, 1'b1};
    tbl[3] = '{4'b1001, 8'hC3, 4'b1000, 2'd3, 1'b1};
    tbl[4] = '{4'b0110, 8'h81, 4'b0010, 2'd1, 1'b1};
    tbl[5] = '{4'b0011, 8'h7E, 4'b0001, 2'd0, 1'b1};
    tbl[6] = '{4'b0000, 8'hFF, 4'b0000, 2'd0, 1'b0};
    tbl[7] = '{4'b1111, 8'h42, 4'b0010, 2'd1, 1'b1};

    do_reset();
    check("reset_busy", busy, 0);
    check("reset_txreq", tx_request, 0);
    check("reset_txdata", tx_data, 0);
    check("reset_gid", grant_id, 0);

    // ---- table-driven grants ----
    for (int t = 0; t < 8; t++) begin
      req_valid = tbl[t].valid;
      req_data  = lanes(tbl[t].data);
      #1;
      check($sformatf("tbl%0d_ready", t), req_ready, tbl[t].exp_ready);
      tick();
      req_valid = '0;
      check($sformatf("tbl%0d_gid", t), grant_id, tbl[t].exp_gid);
      check($sformatf("tbl%0d_busy", t), busy, tbl[t].exp_acc);
      if (tbl[t].exp_acc) begin
        check($sformatf("tbl%0d_txdata", t), tx_data, tbl[t].data ^ (8'h11 * 8'(tbl[t].exp_gid)));
        check($sformatf("tbl%0d_txreq", t), tx_request, 1);
        repeat (FRAME) tick();
      end
      check($sformatf("tbl%0d_idle", t), busy, 0);
    end

    // ---- single request: launch and slot lengths ----
    do_reset();
    req_valid = 4'b0100;
    req_data  = '0;
    req_data[23:16] = 8'hA5;
    #1;
    check("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check("single_txdata", tx_data, 8'hA5);
    check("single_gid", grant_id, 2);
    check("single_txreq_first", tx_request, 1);
    cnt_req  = 0;
    cnt_busy = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx_request) cnt_req++;
      if (busy) cnt_busy++;
      if (tx_request && c >= LAUNCH) check("single_txreq_late", c, LAUNCH - 1);
      tick();
    end
    check("single_txreq_cycles", cnt_req, LAUNCH);
    check("single_busy_cycles", cnt_busy, FRAME);

    // ---- round-robin fairness with all requesters held valid ----
    do_reset();
    req_valid = 4'b1111;
    req_data  = lanes(8'h10);
    for (int c = 0; c < 300 && acc_ids.size() < 5; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        acc_times.push_back(c);
        acc_ids.push_back(onehot_idx(req_valid & req_ready));
      end
    end
    tick();
    req_valid = '0;
    check("rr_grant_count", acc_ids.size(), 5);
    if (acc_ids.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("rr_id%0d", k), acc_ids[k], k % 4);
        if (k > 0) check($sformatf("rr_gap%0d", k), acc_times[k] - acc_times[k-1], FRAME + 1);
      end
    end

    // ---- asynchronous reset mid-LAUNCH ----
    do_reset();
    req_valid = 4'b0100;
    req_data  = lanes(8'h99);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("pre_rst_busy", busy, 1);
    check("pre_rst_gid", grant_id, 2);
    #2;
    reset     = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("arst_txreq", tx_request, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", req_ready, 0);
    check("arst_gid", grant_id, 0);
    check("arst_txdata", tx_data, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_tie_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("post_rst_gid", grant_id, 0);
    repeat (FRAME) tick();

    // ---- request arriving during HOLD waits for IDLE ----
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (20) tick();
    req_valid = 4'b0010;
    elapsed = 0;
    while (busy && elapsed < 60) begin
      if (req_ready !== 4'b0000) check("hold_ready_zero", req_ready, 0);
      tick();
      elapsed++;
    end
    check("hold_wait_cycles", elapsed, FRAME - 20);
    check("hold_ready_idle", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    check("hold_gid", grant_id, 1);
    check("hold_busy", busy, 1);

    // ---- withdrawn request during LAUNCH ----
    tick();
    tick();
    req_valid = 4'b0100;
    #1;
    check("wd_ready_launch", req_ready, 0);
    tick();
    req_valid = '0;
    repeat (FRAME - 3) tick();
    check("wd_idle", busy, 0);
    check("wd_gid", grant_id, 1);
    check("wd_ready", req_ready, 0);
    repeat (3) tick();
    check("wd_still_idle", busy, 0);

    // ---- randomized stimulus against the reference model ----
    do_reset();
    m_age  = -1;
    m_ptr  = 0;
    m_gid  = 0;
    m_data = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) req_valid[i] = ($urandom_range(0, 7) == 0);
      req_data = $urandom;
      @(negedge clk);
      w = rr_pick(req_valid, m_ptr);
      e_ready = (m_age < 0 && w >= 0) ? (4'b1 << w) : 4'b0;
      exp_vec = {e_ready, 1'(m_age >= 0 && m_age < LAUNCH), 1'(m_age >= 0), 2'(m_gid), m_data};
      act_vec = {req_ready, tx_request, busy, grant_id, tx_data};
      if (act_vec !== exp_vec) check($sformatf("rand_c%0d", c), act_vec, exp_vec);
      else n_checks++;
      @(posedge clk);
      if (m_age < 0) begin
        if (w >= 0) begin
          m_gid  = w;
          m_data = req_data[w*8 +: 8];
          m_ptr  = (w + 1) % NUM_REQ;
          m_age  = 0;
        end
      end else begin
        m_age++;
        if (m_age == FRAME) m_age = -1;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
